// File: rtl/mem_stall_ctrl.sv
// Memory stall controller: sequences the shared memory port for the
// writeback-stage op and freezes the pipeline while it is pending.
//
// Ports:
//   clk, rstd        clock, async active-low reset
//   jon[2:0]         mem-op flags per stage (0 dec, 1 exe, 2 wb)
//   st_w             writeback op is a store
//   mem_ready        memory completes the request this cycle
//   mem_rdata        read data, valid with mem_ready
//   mem_req, mem_we  memory request / write strobe
//   freeze           hold PC and all pipeline registers
//   rdata_q          last captured load data
//   err              sticky timeout flag
//   stall_cnt        frozen cycles, saturating
//   acc_cnt          completed accesses, wrapping
//   state            FSM state (IDLE=0, ACCESS=1, DONE=2)
module mem_stall_ctrl #(
    parameter int DW      = 32,
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rstd,
    input  logic [2:0]       jon,
    input  logic             st_w,
    input  logic             mem_ready,
    input  logic [DW-1:0]    mem_rdata,
    output logic             mem_req,
    output logic             mem_we,
    output logic             freeze,
    output logic [DW-1:0]    rdata_q,
    output logic             err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] acc_cnt,
    output logic [1:0]       state
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;

    // wait counter only needs to reach TIMEOUT-1
    localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);

    logic [1:0]    state_q;
    logic [1:0]    state_d;
    logic [WW-1:0] wait_q;
    logic          in_idle;
    logic          timeout;

    assign in_idle = (state_q == S_IDLE);
    assign mem_req = (state_q == S_ACCESS);
    assign mem_we  = mem_req & st_w;
    assign timeout = mem_req & ~mem_ready & (wait_q == WAIT_LAST);
    assign state   = state_q;

    // freeze is combinational on jon[2] in IDLE; gate it with reset
    // so it reads 0 while rstd is held low
    assign freeze = rstd & (mem_req | (in_idle & jon[2]));

    always_comb begin
        state_d = S_IDLE;
        case (state_q)
            S_IDLE:   state_d = jon[2] ? S_ACCESS : S_IDLE;
            S_ACCESS: state_d = (mem_ready | timeout) ? S_DONE : S_ACCESS;
            // jon[2] here belongs to the retiring op
            S_DONE:   state_d = jon[1] ? S_ACCESS : S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstd) begin
        if (!rstd) begin
            state_q   <= S_IDLE;
            wait_q    <= '0;
            rdata_q   <= '0;
            err       <= 1'b0;
            stall_cnt <= '0;
            acc_cnt   <= '0;
        end else begin
            state_q <= state_d;

            // cleared in every non-ACCESS cycle, so zero on entry
            if (mem_req && !mem_ready) begin
                wait_q <= wait_q + WW'(1);
            end else begin
                wait_q <= '0;
            end

            if (freeze && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end

            if (mem_req && mem_ready) begin
                acc_cnt <= acc_cnt + CNT_W'(1);
                if (!st_w) begin
                    rdata_q <= mem_rdata;
                end
            end

            if (timeout) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_stall_ctrl.sv
// Scoreboard bench for mem_stall_ctrl: transaction-level model
// predicts each access; a monitor checks every mem_req burst.
module tb_mem_stall_ctrl;

    localparam int DW = 32;
    localparam int TO = 15;

    logic          clk = 1'b0;
    logic          rstd;
    logic [2:0]    jon;
    logic          st_w;
    logic          mem_ready;
    logic [DW-1:0] mem_rdata;

    logic          mem_req, mem_we, freeze, err;
    logic [DW-1:0] rdata_q;
    logic [15:0]   stall_cnt, acc_cnt;
    logic [1:0]    state;

    logic          mem_req4, mem_we4, freeze4, err4;
    logic [DW-1:0] rdata_q4;
    logic [3:0]    stall_cnt4, acc_cnt4;
    logic [1:0]    state4;

    always #5 clk = ~clk;

    mem_stall_ctrl #(.DW(DW), .TIMEOUT(TO), .CNT_W(16)) dut (
        .clk(clk), .rstd(rstd), .jon(jon), .st_w(st_w),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .freeze(freeze),
        .rdata_q(rdata_q), .err(err), .stall_cnt(stall_cnt),
        .acc_cnt(acc_cnt), .state(state)
    );

    // narrow-counter copy on the same stimulus for saturation/wrap
    mem_stall_ctrl #(.DW(DW), .TIMEOUT(TO), .CNT_W(4)) dut4 (
        .clk(clk), .rstd(rstd), .jon(jon), .st_w(st_w),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .mem_req(mem_req4), .mem_we(mem_we4), .freeze(freeze4),
        .rdata_q(rdata_q4), .err(err4), .stall_cnt(stall_cnt4),
        .acc_cnt(acc_cnt4), .state(state4)
    );

    typedef struct {
        int            req_len;
        bit            we;
        logic [DW-1:0] rdata;
        int            acc;
        bit            err;
        int            stall;
        bit            b2b;
    } exp_t;

    typedef struct {
        bit            store;
        int            waits;
        bit            tmo;
        logic [DW-1:0] data;
        bit            b2b;
        int            gap;
    } tx_t;

    exp_t sb[$];
    tx_t  txs[$];

    int n_checks = 0;
    int n_fail   = 0;
    bit mon_en   = 1'b0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // ---------------- monitor ----------------
    int   run      = 0;
    bit   pend_b2b = 1'b0;
    exp_t cur;

    always @(negedge clk) begin
        if (mon_en) begin
            if (pend_b2b) begin
                chk("b2b_access", {63'd0, mem_req}, 64'd1);
                pend_b2b = 1'b0;
            end
            if (mem_req) begin
                if (run == 0) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_req", 64'd1, 64'd0);
                    end else begin
                        cur = sb[0];
                    end
                end
                run++;
                chk("mem_we", {63'd0, mem_we}, {63'd0, cur.we});
            end else begin
                chk("we_idle", {63'd0, mem_we}, 64'd0);
                if (run > 0 && sb.size() > 0) begin
                    cur = sb.pop_front();
                    chk("req_len", 64'(run), 64'(cur.req_len));
                    chk("done_state", {62'd0, state}, 64'd2);
                    chk("done_freeze", {63'd0, freeze}, 64'd0);
                    chk("rdata_q", 64'(rdata_q), 64'(cur.rdata));
                    chk("acc_cnt", 64'(acc_cnt), 64'(cur.acc % 65536));
                    chk("err", {63'd0, err}, {63'd0, cur.err});
                    chk("stall_cnt", 64'(stall_cnt), 64'(cur.stall));
                    chk("stall_sat4", 64'(stall_cnt4),
                        64'((cur.stall > 15) ? 15 : cur.stall));
                    chk("acc_wrap4", 64'(acc_cnt4), 64'(cur.acc % 16));
                    pend_b2b = cur.b2b;
                end
                run = 0;
            end
        end
    end

    // ---------------- driver + model ----------------
    int            m_acc   = 0;
    bit            m_err   = 1'b0;
    logic [DW-1:0] m_rdata = '0;
    int            m_stall = 0;

    task automatic add_tx(input bit s, input int w, input bit t,
                          input logic [DW-1:0] d, input bit b,
                          input int g);
        tx_t x;
        x.store = s; x.waits = w; x.tmo = t;
        x.data = d; x.b2b = b; x.gap = g;
        txs.push_back(x);
    endtask

    task automatic run_tx(input tx_t x, input bit prev_b2b);
        int   len;
        exp_t e;
        len = x.tmo ? TO : x.waits + 1;
        if (!prev_b2b) begin
            for (int g = 0; g < x.gap; g++) begin
                jon = {1'b0, 2'($urandom)};
                st_w = 1'($urandom);
                mem_ready = 1'($urandom);
                mem_rdata = $urandom;
                step();
            end
            jon = {1'b1, 2'($urandom)};
            st_w = x.store;
            mem_ready = 1'($urandom);
            step();
        end
        m_stall += (prev_b2b ? 0 : 1) + len;
        if (x.tmo) begin
            m_err = 1'b1;
        end else begin
            m_acc++;
            if (!x.store) m_rdata = x.data;
        end
        e.req_len = len; e.we = x.store; e.rdata = m_rdata;
        e.acc = m_acc; e.err = m_err; e.stall = m_stall;
        e.b2b = x.b2b;
        sb.push_back(e);
        for (int c = 0; c < len; c++) begin
            jon = {1'b1, 2'($urandom)};
            st_w = x.store;
            mem_ready = !x.tmo && (c == len - 1);
            mem_rdata = mem_ready ? x.data : $urandom;
            step();
        end
        jon = {1'($urandom), x.b2b, 1'($urandom)};
        st_w = 1'($urandom);
        mem_ready = 1'($urandom);
        mem_rdata = $urandom;
        step();
    endtask

    initial begin
        int k;
        rstd = 1'b0;
        jon = 3'b111;
        st_w = 1'b0;
        mem_ready = 1'b1;
        mem_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        @(negedge clk);
        chk("rst_freeze", {63'd0, freeze}, 64'd0);
        chk("rst_req", {63'd0, mem_req}, 64'd0);
        chk("rst_err", {63'd0, err}, 64'd0);
        chk("rst_stall", 64'(stall_cnt), 64'd0);
        chk("rst_acc", 64'(acc_cnt), 64'd0);
        chk("rst_rdata", 64'(rdata_q), 64'd0);
        chk("rst_state", {62'd0, state}, 64'd0);
        step();
        jon = 3'b000;
        mem_ready = 1'b0;
        rstd = 1'b1;
        mon_en = 1'b1;

        add_tx(1'b0, 0, 1'b0, 32'hDEAD_BEEF, 1'b0, 1);
        add_tx(1'b1, 3, 1'b0, 32'h1234_5678, 1'b0, 1);
        add_tx(1'b0, 1, 1'b0, 32'hA5A5_0001, 1'b1, 1);
        add_tx(1'b0, 0, 1'b0, 32'h0BAD_F00D, 1'b0, 1);
        add_tx(1'b0, 0, 1'b1, 32'h7777_7777, 1'b0, 2);
        add_tx(1'b0, 2, 1'b0, 32'hCAFE_0042, 1'b0, 1);
        for (int i = 0; i < 25; i++) begin
            add_tx(1'($urandom), int'($urandom_range(0, 5)),
                   ($urandom_range(0, 9) == 0),
                   $urandom, ($urandom_range(0, 2) == 0) && (i != 24),
                   int'($urandom_range(0, 2)));
        end

        for (int i = 0; i < txs.size(); i++) begin
            run_tx(txs[i], (i > 0) && txs[i-1].b2b);
        end
        jon = 3'b000;
        k = 0;
        while ((sb.size() != 0) && (k < 40)) begin
            step();
            k++;
        end
        chk("drain", 64'(sb.size()), 64'd0);
        step();
        mon_en = 1'b0;

        // asynchronous reset in the middle of an access
        jon = 3'b100;
        st_w = 1'b0;
        mem_ready = 1'b0;
        step();
        #1;
        chk("mid_req_pre", {63'd0, mem_req}, 64'd1);
        rstd = 1'b0;
        #1;
        chk("mid_req", {63'd0, mem_req}, 64'd0);
        chk("mid_freeze", {63'd0, freeze}, 64'd0);
        chk("mid_state", {62'd0, state}, 64'd0);
        chk("mid_acc", 64'(acc_cnt), 64'd0);
        chk("mid_err", {63'd0, err}, 64'd0);
        jon = 3'b000;
        step();
        rstd = 1'b1;
        step();
        chk("post_state", {62'd0, state}, 64'd0);
        jon = 3'b100;
        #1;
        chk("post_freeze", {63'd0, freeze}, 64'd1);
        step();
        #1;
        chk("post_req", {63'd0, mem_req}, 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_stall_ctrl.md
# mem_stall_ctrl

Pipeline freeze controller that consumes the per-stage memory-op flags `jon[2:0]` and sequences the single shared memory port for the instruction in the writeback stage. While the access is pending it holds the whole pipeline (PC and all stage registers) and captures load data on completion. It keeps stall and access performance counters and flags memory timeouts.

## Interface
- `DW`, 32: memory data width
- `TIMEOUT`, 15: maximum `mem_req` cycles per access before abort (≥1)
- `CNT_W`, 16: width of the performance counters

- `clk` in 1: clock, rising edge
- `rstd` in 1: reset, asynchronous, active-low
- `jon` in 3: memory-op flags. [0] decode, [1] execute, [2] writeback. 1 = opcode 32–35 or 40–42.
- `st_w` in 1: writeback op is a store (opcode 40–42). Valid when `jon[2]`=1.
- `mem_ready` in 1: memory completes the current request this cycle
- `mem_rdata` in DW: read data, valid with `mem_ready`
- `mem_req` out 1: access request to memory
- `mem_we` out 1: request is a write
- `freeze` out 1: 1 holds PC and all pipeline registers
- `rdata_q` out DW: last captured load data
- `err` out 1: sticky timeout flag
- `stall_cnt` out CNT_W: cycles with `freeze`=1, saturating
- `acc_cnt` out CNT_W: completed accesses, wrapping
- `state` out 2: FSM state for debug. IDLE=0, ACCESS=1, DONE=2.

## Operation
- **IDLE**
  - `mem_req`=0.
  - `freeze` = `jon[2]` (combinational).
  - If `jon[2]`=1, go to ACCESS. Otherwise stay in IDLE.
- **ACCESS**
  - `mem_req`=1, `freeze`=1, `mem_we` = `st_w` (combinational; stable because the pipeline is frozen).
  - On `mem_ready`=1:
    - Go to DONE and increment `acc_cnt`.
    - If `st_w`=0, load `rdata_q` ← `mem_rdata`.
  - On `mem_ready`=0: increment the wait counter. If the wait counter reaches `TIMEOUT`-1 in a cycle without `mem_ready`, set `err`, go to DONE, and leave `rdata_q` and `acc_cnt` unchanged.
  - The wait counter clears on entry to ACCESS.
- **DONE**
  - `mem_req`=0, `freeze`=0. The writeback instruction retires and the pipeline advances one step.
  - `jon[2]` is ignored here, because it belongs to the retiring instruction.
  - If `jon[1]`=1, go directly to ACCESS (back-to-back; the execute-stage op is in writeback next cycle). Otherwise go to IDLE.
- `jon[0]` is reserved and ignored in this revision.
- `stall_cnt`: +1 every cycle `freeze`=1, held at 2^CNT_W−1 once reached.
- `acc_cnt`: +1 per completed access, mod 2^CNT_W.
- `err` clears only on reset. The FSM keeps operating after `err` is set.
- `mem_we`=0 whenever `mem_req`=0.
- Illegal state encoding (3) goes to IDLE on the next cycle.
- Reset values: state=IDLE, all outputs 0 (`mem_req`, `mem_we`, `freeze`, `rdata_q`, `err`, counters).

## Timing
- Zero-wait access from IDLE: 3 cycles (IDLE+ACCESS+DONE), `freeze`=1 for 2 cycles.
- N wait cycles: `mem_req` high N+1 cycles, `freeze` high N+2 cycles.
- Back-to-back: DONE→ACCESS saves the IDLE cycle. Between two accesses `freeze` is low for exactly 1 cycle.
- Timeout: `mem_req` high exactly `TIMEOUT` cycles. `err` is visible the cycle after the last `mem_req` cycle.
- `rdata_q`, `acc_cnt` and `err` update on the clock edge ending the qualifying ACCESS cycle. They are visible in DONE.
- Reset mid-access (`rstd` low in any state): outputs go to reset values immediately (asynchronously) and `mem_req` drops without waiting for `mem_ready`. After `rstd` rises, operation resumes from IDLE.

## Test plan
- **Reset:** `rstd`=0 with `jon`=3'b111 and `mem_ready`=1 → `freeze`=0, `mem_req`=0, `err`=0, counters=0, `rdata_q`=0.
- **Zero-wait load:** `jon`=3'b100, `st_w`=0, `mem_ready`=1, `mem_rdata`=32'hDEADBEEF → `freeze`=1 for 2 cycles, `mem_req`=1 for 1 cycle, `mem_we`=0, `rdata_q`=32'hDEADBEEF, `acc_cnt`=1, `stall_cnt`=2.
- **Store with 3 wait cycles:** `jon[2]`=1, `st_w`=1, `mem_ready` high on the 4th ACCESS cycle → `mem_req`=`mem_we`=1 for 4 cycles, `freeze`=1 for 5 cycles, `rdata_q` unchanged, `acc_cnt`+1.
- **Back-to-back loads:** `jon[1]`=1 during DONE → state goes to 1 on the next cycle with no IDLE, `freeze`=0 for exactly 1 cycle between accesses, `acc_cnt`=2.
- **Timeout:** `TIMEOUT`=15, `mem_ready` held 0 → `mem_req` high for 15 cycles, then `err`=1, `acc_cnt`=0. A later normal access completes with `err` still 1.
- **Saturation and reset mid-access:** `CNT_W`=4 with 20 stall cycles → `stall_cnt`=15. `rstd` pulsed low mid-ACCESS → `mem_req`=0 and `freeze`=0 immediately, state=0.
